// File: rtl/read_address_counter.sv
// Read-side pointer for a small register file: one-hot read ring, occupancy
// tracking against write pulses, registered read address with a valid strobe.
module read_address_counter #(
  parameter int DEPTH = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic       wr_en,
  input  logic       rd_req,
  output logic [3:0] ReadReg,
  output logic       rd_valid,
  output logic       empty,
  output logic       full,
  output logic [3:0] count,
  output logic       overflow
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  logic [DEPTH-1:0] ring_q, ring_d;
  logic [3:0]       read_reg_q, read_reg_d;
  logic             rd_valid_q, rd_valid_d;
  logic [3:0]       count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             empty_w, full_w, rd_acc, wr_acc;
  logic [3:0]       ptr_addr;

  assign empty_w = (count_q == 4'd0);
  assign full_w  = (count_q == DEPTH_L);
  assign rd_acc  = Start && rd_req && !empty_w;
  // A read in the same cycle frees the slot the write would otherwise lack.
  assign wr_acc  = Start && wr_en && (!full_w || rd_acc);

  always_comb begin
    ptr_addr = '0;
    for (int k = 0; k < DEPTH; k++)
      if (ring_q[k]) ptr_addr = ptr_addr | 4'(k);
  end

  always_comb begin
    ring_d     = ring_q;
    read_reg_d = read_reg_q;
    rd_valid_d = rd_acc;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (rd_acc) begin
      read_reg_d = ptr_addr;
      ring_d     = {ring_q[DEPTH-2:0], ring_q[DEPTH-1]};
    end
    if (wr_acc && !rd_acc)      count_d = count_q + 4'd1;
    else if (rd_acc && !wr_acc) count_d = count_q - 4'd1;
    if (Start && wr_en && full_w && !rd_acc) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q     <= DEPTH'(1);
      read_reg_q <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ring_q     <= ring_d;
      read_reg_q <= read_reg_d;
      rd_valid_q <= rd_valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign ReadReg  = read_reg_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_read_address_counter.sv
// Bench for read_address_counter: integer-arithmetic reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_read_address_counter;
  localparam int DEPTH = 15;

  logic       clk = 1'b0;
  logic       rst, Start, wr_en, rd_req;
  logic [3:0] ReadReg, count;
  logic       rd_valid, empty, full, overflow;

  int total = 0;
  int bad   = 0;

  // reference state: oldest-entry address as an integer, occupancy, outputs
  int m_ptr = 0, m_cnt = 0, m_rreg = 0;
  bit m_rv = 0, m_ovf = 0;

  read_address_counter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .Start(Start), .wr_en(wr_en), .rd_req(rd_req),
    .ReadReg(ReadReg), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit ra, wa;
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_rreg = 0; m_rv = 0; m_ovf = 0;
    end else begin
      ra = Start && rd_req && (m_cnt > 0);
      wa = Start && wr_en && ((m_cnt < DEPTH) || ra);
      if (Start && wr_en && m_cnt == DEPTH && !ra) m_ovf = 1;
      m_rv = ra;
      if (ra) begin
        m_rreg = m_ptr;
        m_ptr  = (m_ptr + 1) % DEPTH;
      end
      m_cnt = m_cnt + int'(wa) - int'(ra);
    end
  endtask

  task automatic compare_model();
    chk("ReadReg",  int'(ReadReg),  m_rreg);
    chk("rd_valid", int'(rd_valid), int'(m_rv));
    chk("count",    int'(count),    m_cnt);
    chk("empty",    int'(empty),    int'(m_cnt == 0));
    chk("full",     int'(full),     int'(m_cnt == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic step(input bit r, input bit s, input bit w, input bit q);
    rst = r; Start = s; wr_en = w; rd_req = q;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  initial begin
    int p_wr, p_rd;
    rst = 1; Start = 0; wr_en = 0; rd_req = 0;
    #1;

    // reset state
    step(1, 1, 1, 1);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_readreg", int'(ReadReg), 0);
    chk("rst_rdvalid", int'(rd_valid), 0);

    // three writes then three reads
    repeat (3) step(0, 1, 1, 0);
    chk("w3_count", int'(count), 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1);
      chk("r3_addr", int'(ReadReg), i);
      chk("r3_valid", int'(rd_valid), 1);
    end
    step(0, 1, 0, 0);
    chk("r3_valid_drop", int'(rd_valid), 0);
    chk("r3_empty", int'(empty), 1);

    // fill, drain, wrap
    step(1, 0, 0, 0);
    repeat (15) step(0, 1, 1, 0);
    chk("fill_full", int'(full), 1);
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 1);
      chk("drain_addr", int'(ReadReg), i);
    end
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    chk("wrap_addr", int'(ReadReg), 0);
    chk("wrap_valid", int'(rd_valid), 1);

    // overflow when full, then simultaneous read/write at full
    step(1, 0, 0, 0);
    repeat (15) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 15);
    step(0, 1, 1, 1);
    chk("full_rw_count", int'(count), 15);
    chk("full_rw_ovf", int'(overflow), 1);

    // empty with write+read together
    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    chk("empty_rw_count", int'(count), 1);
    chk("empty_rw_valid", int'(rd_valid), 0);
    step(0, 1, 0, 1);
    chk("empty_rw_addr", int'(ReadReg), 0);
    chk("empty_rw_valid2", int'(rd_valid), 1);

    // Start low freezes everything
    repeat (3) step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, i[0], ~i[0]);
      chk("frz_count", int'(count), 2);
      chk("frz_addr", int'(ReadReg), 1);
      chk("frz_valid", int'(rd_valid), 0);
    end
    step(0, 1, 0, 1);
    chk("resume_addr", int'(ReadReg), 2);

    // reset mid-stream with a read request
    step(1, 0, 0, 0);
    repeat (4) step(0, 1, 1, 0);
    repeat (2) step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("midrst_count", int'(count), 0);
    chk("midrst_addr", int'(ReadReg), 0);
    chk("midrst_valid", int'(rd_valid), 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    chk("midrst_first", int'(ReadReg), 0);

    // random traffic with phases biased toward fill and drain
    for (int ph = 0; ph < 30; ph++) begin
      case (ph % 3)
        0: begin p_wr = 85; p_rd = 30; end
        1: begin p_wr = 30; p_rd = 85; end
        default: begin p_wr = 60; p_rd = 60; end
      endcase
      for (int c = 0; c < 60; c++)
        step($urandom_range(0, 99) < 2, $urandom_range(0, 7) != 0,
             $urandom_range(0, 99) < p_wr, $urandom_range(0, 99) < p_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/read_address_counter.md
READ_ADDRESS_COUNTER -- requirements
Module: read_address_counter

Interface
REQ-001 Parameter DEPTH, default 15, number of register-file entries tracked; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 Start  input  1  enable; when 0 no pointer, occupancy or flag changes (rst excepted).
REQ-005 wr_en  input  1  write-side advance pulse, one per cycle, same cycle as write counter advance.
REQ-006 rd_req  input  1  request to read the oldest written entry.
REQ-007 ReadReg  output  4  registered read address, binary, range 0..DEPTH-1.
REQ-008 rd_valid  output  1  one-cycle pulse; ReadReg holds a newly accepted address.
REQ-009 empty  output  1  occupancy == 0.
REQ-010 full  output  1  occupancy == DEPTH.
REQ-011 count  output  4  current occupancy, 0..DEPTH.
REQ-012 overflow  output  1  sticky; a write arrived while full with no accepted read.

Function
REQ-013 Read pointer SHALL be a DEPTH-bit one-hot ring; bit k encodes to address k; exactly one bit set at all times.
REQ-014 Read accept SHALL be Start && rd_req && !empty, evaluated on pre-edge state.
REQ-015 Write accept SHALL be Start && wr_en && (!full || read accept).
REQ-016 On read accept the ring SHALL rotate one position; bit DEPTH-1 wraps to bit 0.
REQ-017 Latency: on the edge of read accept, ReadReg SHALL load the pre-rotation address and rd_valid SHALL be 1 for the following cycle only.
REQ-018 Without read accept, ReadReg SHALL hold its value and rd_valid SHALL be 0.
REQ-019 Occupancy update: +1 write only; -1 read only; unchanged for both or neither.
REQ-020 Empty with wr_en and rd_req together: write accepted, read rejected, count becomes 1, rd_valid stays 0.
REQ-021 Full with wr_en and rd_req together: both accepted, count stays DEPTH, overflow unchanged.
REQ-022 Full with wr_en, no read accept: write dropped, count stays DEPTH, overflow set to 1 and held until rst.
REQ-023 rd_req while empty SHALL be ignored with no state change.
REQ-024 empty, full, count SHALL be derived from the registered occupancy, no combinational path from inputs.
REQ-025 Start deasserted mid-stream SHALL freeze all state; reassertion resumes from the frozen pointer and count.

Reset
REQ-026 rst=1 at a clock edge SHALL set ring to bit 0, ReadReg=0, rd_valid=0, count=0, empty=1, full=0, overflow=0.
REQ-027 rst SHALL take priority over Start, wr_en and rd_req in the same cycle.
REQ-028 rst asserted mid-operation SHALL discard occupancy and pointer; first read after rst returns address 0.

Verification
REQ-029 rst then Start=1, 3 wr_en pulses, then 3 rd_req cycles -> ReadReg 0,1,2 each with rd_valid pulse one cycle after accept; count 3->0; empty=1.
REQ-030 DEPTH=15: 15 writes, 15 reads, 1 write, 1 read -> full=1 after 15th write; 16th read address wraps to 0.
REQ-031 Full, wr_en without rd_req -> overflow=1, count=15; subsequent wr_en+rd_req -> count stays 15, overflow stays 1.
REQ-032 Empty, wr_en and rd_req same cycle -> count=1, rd_valid=0; next rd_req -> ReadReg=current pointer, rd_valid=1.
REQ-033 Start=0 with wr_en and rd_req toggling 5 cycles -> count, ReadReg, pointer unchanged; rd_valid=0.
REQ-034 After 4 writes and 2 reads, rst=1 together with rd_req -> count=0, ReadReg=0, rd_valid=0; next write+read yields address 0.
